// File: rtl/bram_reader_pkg.sv
// Shared types and width helpers for the block-RAM stream reader.
package bram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int len_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bram_reader_skid_fifo.sv
// Two-entry buffer between the RAM read port and the output stream; output is
// taken from registers only, so data_out_B never reaches m_data combinationally.
module bram_reader_skid_fifo #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             pop;

  assign pop       = valid && ready;
  assign valid     = (count != 2'd0);
  assign data      = mem[rd_ptr];
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Streams a block of words out of RAM port B. Optional macro
// BRAM_STREAM_READER_LOOP_EN adds loop_enable to replay the block continuously.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter  int RAM_WIDTH = 16,
  parameter  int RAM_DEPTH = 1024,
  localparam int ADDR_W    = addr_w(RAM_DEPTH),
  localparam int LEN_W     = len_w(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef BRAM_STREAM_READER_LOOP_EN
  input  logic                 loop_enable,
`endif
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_address,
  input  logic [LEN_W-1:0]     length,
  output logic                 busy,
  output logic                 done,
  output logic                 read_enable_B,
  output logic [ADDR_W-1:0]    address_B,
  input  logic [RAM_WIDTH-1:0] data_out_B,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready
);

  // Stream handshake: a word moves when m_valid && m_ready on a rising edge;
  // m_valid never drops and m_data never changes until that happens.

  reader_state_t     state, state_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [LEN_W-1:0]  remaining_q, remaining_next;
  logic              in_flight_q;
  logic              zero_len_q, zero_len_next;
  logic [1:0]        occupancy;
  logic [2:0]        credit_sum;
  logic              pop, issue, drain_done;

`ifdef BRAM_STREAM_READER_LOOP_EN
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
`endif

  bram_reader_skid_fifo #(.WIDTH(RAM_WIDTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_flight_q),
    .push_data (data_out_B),
    .ready     (m_ready),
    .data      (m_data),
    .valid     (m_valid),
    .occupancy (occupancy)
  );

  // A new read may only go out if its word is guaranteed a free slot on arrival.
  always_comb begin
    pop        = m_valid && m_ready;
    credit_sum = {1'b0, occupancy} + {2'b00, in_flight_q} - {2'b00, pop};
    issue      = (state == READ) && (remaining_q != '0) && (credit_sum < 3'd2);
    drain_done = (state == DRAIN) && (occupancy == 2'd0) && !in_flight_q;
  end

  always_comb begin
    state_next     = state;
    addr_next      = addr_q;
    remaining_next = remaining_q;
    zero_len_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_next     = READ;
            addr_next      = start_address;
            remaining_next = length;
          end else begin
            zero_len_next = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_next      = (addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
          remaining_next = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
`ifdef BRAM_STREAM_READER_LOOP_EN
          if (loop_enable) begin
            state_next     = READ;
            addr_next      = base_q;
            remaining_next = len_q;
          end else begin
            state_next = IDLE;
          end
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      in_flight_q <= 1'b0;
      zero_len_q  <= 1'b0;
    end else begin
      state       <= state_next;
      addr_q      <= addr_next;
      remaining_q <= remaining_next;
      in_flight_q <= issue;
      zero_len_q  <= zero_len_next;
    end
  end

`ifdef BRAM_STREAM_READER_LOOP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      len_q  <= '0;
    end else if (state == IDLE && start && length != '0) begin
      base_q <= start_address;
      len_q  <= length;
    end
  end
`endif

  assign busy          = (state != IDLE);
  assign done          = drain_done || zero_len_q;
  assign read_enable_B = issue;
  assign address_B     = addr_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural 1-cycle-latency RAM.
module tb_bram_stream_reader;

  localparam int W  = 16;
  localparam int D  = 1024;
  localparam int AW = 10;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_address;
  logic [LW-1:0] length;
  logic          busy, done, read_enable_B, m_valid, m_ready;
  logic [AW-1:0] address_B;
  logic [W-1:0]  data_out_B, m_data;

  int tests  = 0;
  int failed = 0;

  bram_stream_reader #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef BRAM_STREAM_READER_LOOP_EN
    .loop_enable   (1'b0),
`endif
    .start         (start),
    .start_address (start_address),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .read_enable_B (read_enable_B),
    .address_B     (address_B),
    .data_out_B    (data_out_B),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM port B model
  logic [W-1:0] ram [D];
  always @(posedge clk) if (read_enable_B) data_out_B <= ram[address_B];

  // monitor
  logic [W-1:0]  got_q[$];
  int            got_cyc[$];
  logic [AW-1:0] addr_q[$];
  logic [W-1:0]  exp_q[$];
  int            done_cnt, done_cyc, start_cyc, stall_err;
  bit            busy_seen, hold_pending;
  logic [W-1:0]  hold_data;
  int            ready_mode;

  always @(negedge clk) begin
    if (start && !busy) start_cyc = cyc;
    if (read_enable_B) addr_q.push_back(address_B);
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      got_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_seen = 1'b1;
    if (hold_pending && (!m_valid || m_data !== hold_data)) stall_err++;
    hold_pending = m_valid && !m_ready;
    hold_data    = m_data;
  end

  // driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = ~m_ready;
      default: m_ready = 1'b0;
    endcase
  endtask

  task automatic clear_mon();
    got_q.delete(); got_cyc.delete(); addr_q.delete(); exp_q.delete();
    done_cnt = 0; done_cyc = -1; start_cyc = -1; stall_err = 0; busy_seen = 1'b0;
  endtask

  task automatic do_start(input int a, input int l);
    step();
    start = 1'b1; start_address = AW'(a); length = LW'(l);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) step();
    check(tag, done_cnt > d0, 1);
  endtask

  // scoreboard
  task automatic check_stream(input string tag, input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(W'((base + i) % D));
    check({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      if (i < got_q.size()) check(tag, got_q[i], e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < D; i++) ram[i] = W'(i);
    reset = 1'b1; start = 1'b0; start_address = '0; length = '0;
    m_ready = 1'b0; ready_mode = 0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_re", read_enable_B, 0);
    check("rst_addr", address_B, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    reset = 1'b0;
    m_ready = 1'b1;
    step();

    // full throughput, m_ready always high
    clear_mon(); ready_mode = 0;
    do_start(0, 8);
    wait_done("a_done_seen", 60);
    step();
    check_stream("a_data", 0, 8);
    if (got_q.size() == 8) begin
      check("a_first_valid", got_cyc[0] - start_cyc, 3);
      check("a_back2back", got_cyc[7] - got_cyc[0], 7);
      check("a_done_lat", done_cyc - got_cyc[7], 1);
    end
    check("a_done_cnt", done_cnt, 1);
    check("a_busy_end", busy, 0);

    // alternating backpressure
    clear_mon(); ready_mode = 1;
    do_start(0, 8);
    wait_done("b_done_seen", 100);
    step();
    check_stream("b_data", 0, 8);
    check("b_stall_stable", stall_err, 0);
    check("b_done_cnt", done_cnt, 1);

    // address wrap
    clear_mon(); ready_mode = 0;
    do_start(1022, 4);
    wait_done("c_done_seen", 60);
    step();
    check_stream("c_data", 1022, 4);
    check("c_addr_count", addr_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < addr_q.size()) check("c_addr", addr_q[i], (1022 + i) % D);

    // zero length
    clear_mon();
    do_start(5, 0);
    repeat (3) step();
    check("d_done_cnt", done_cnt, 1);
    check("d_done_lat", done_cyc - start_cyc, 1);
    check("d_no_reads", addr_q.size(), 0);
    check("d_no_busy", busy_seen, 0);
    check("d_no_words", got_q.size(), 0);

    // long stall with an ignored start while busy
    clear_mon(); ready_mode = 0;
    do_start(0, 16);
    repeat (5) step();
    ready_mode = 2;
    repeat (4) step();
    do_start(500, 3);
    repeat (15) step();
    check("e_credit", (addr_q.size() - got_q.size()) <= 2, 1);
    check("e_held_valid", m_valid, 1);
    check("e_busy_stall", busy, 1);
    ready_mode = 0;
    wait_done("e_done_seen", 100);
    step();
    check_stream("e_data", 0, 16);
    check("e_reads", addr_q.size(), 16);
    check("e_done_cnt", done_cnt, 1);
    check("e_stall_stable", stall_err, 0);
    check("e_busy_end", busy, 0);

    // reset mid-transfer, then restart
    clear_mon(); ready_mode = 0;
    do_start(0, 8);
    repeat (3) step();
    reset = 1'b1;
    step();
    check("f_busy", busy, 0);
    check("f_done", done, 0);
    check("f_re", read_enable_B, 0);
    check("f_addr", address_B, 0);
    check("f_valid", m_valid, 0);
    check("f_data", m_data, 0);
    reset = 1'b0;
    repeat (5) step();
    check("f_no_done", done_cnt, 0);
    clear_mon();
    do_start(100, 2);
    wait_done("f_done_seen", 60);
    step();
    check_stream("f_restart", 100, 2);
    check("f_done_cnt", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
